// File: rtl/jts16_map_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jts16_map_arb_if                                             |
// | Description : Bundle of the two tile-map reader ports and the SDRAM        |
// |               bank-0 map channel served by jts16_map_arb.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface jts16_map_arb_if #(
  parameter int AW = 14,
  parameter int DW = 16
);
  logic          flush;
  logic [AW-1:0] a_addr;
  logic          a_ok;
  logic [DW-1:0] a_data;
  logic [AW-1:0] b_addr;
  logic          b_ok;
  logic [DW-1:0] b_data;
  logic [AW-1:0] sdr_addr;
  logic          sdr_cs;
  logic          sdr_ok;
  logic [DW-1:0] sdr_data;

  // Arbiter side
  modport slave (
    input  flush, a_addr, b_addr, sdr_ok, sdr_data,
    output a_ok, a_data, b_ok, b_data, sdr_addr, sdr_cs
  );

  // Readers / SDRAM side
  modport master (
    output flush, a_addr, b_addr, sdr_ok, sdr_data,
    input  a_ok, a_data, b_ok, b_data, sdr_addr, sdr_cs
  );
endinterface
`default_nettype wire

// File: rtl/jts16_map_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jts16_map_arb                                                |
// | Description : Shares one SDRAM read slot between the FG (A) and BG (B)     |
// |               tile-map readers. Each reader owns a one-entry tagged cache; |
// |               misses are arbitrated and fetched through the cs/ok handshake.|
// | Options     : JTS16_MAP_ARB_RR_EN - round-robin on simultaneous misses     |
// |               (undefined: A always wins).                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module jts16_map_arb #(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  jts16_map_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_issue;
  logic          w_capture;

  logic          r_gnt;          // 0: reader A, 1: reader B
  logic [AW-1:0] r_sdr_addr;
  logic          r_sdr_cs;
  logic          r_flush_pend;

  logic          r_valid_a;
  logic          r_valid_b;
  logic [AW-1:0] r_tag_a;
  logic [AW-1:0] r_tag_b;
  logic [DW-1:0] r_data_a;
  logic [DW-1:0] r_data_b;

  logic          w_a_ok;
  logic          w_b_ok;
  logic          w_miss_a;
  logic          w_miss_b;
  logic          w_pick_b;

`ifdef JTS16_MAP_ARB_RR_EN
  logic          r_rr;           // reader favoured on the next contested grant
`endif

  // Hit check against the live address: a changed address drops ok at once
  always_comb begin
    w_a_ok   = r_valid_a && (r_tag_a == bus.a_addr);
    w_b_ok   = r_valid_b && (r_tag_b == bus.b_addr);
    w_miss_a = !w_a_ok;
    w_miss_b = !w_b_ok;
`ifdef JTS16_MAP_ARB_RR_EN
    w_pick_b = w_miss_b && (!w_miss_a || r_rr);
`else
    w_pick_b = w_miss_b && !w_miss_a;
`endif
  end

  assign bus.a_ok     = w_a_ok;
  assign bus.a_data   = r_data_a;
  assign bus.b_ok     = w_b_ok;
  assign bus.b_data   = r_data_b;
  assign bus.sdr_addr = r_sdr_addr;
  assign bus.sdr_cs   = r_sdr_cs;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: GAP keeps cs low for its one cycle and may launch the next
  // miss directly, so back-to-back fetches see exactly one low cycle on cs
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_miss_a || w_miss_b) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.sdr_ok) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request launch, data capture and cache invalidation; flush is applied
  // last so it overrides a fill landing on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt        <= 1'b0;
      r_sdr_addr   <= '0;
      r_sdr_cs     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_valid_a    <= 1'b0;
      r_valid_b    <= 1'b0;
      r_tag_a      <= '0;
      r_tag_b      <= '0;
      r_data_a     <= '0;
      r_data_b     <= '0;
`ifdef JTS16_MAP_ARB_RR_EN
      r_rr         <= 1'b0;
`endif
    end else begin
      if (w_issue) begin
        r_gnt      <= w_pick_b;
        r_sdr_addr <= w_pick_b ? bus.b_addr : bus.a_addr;
        r_sdr_cs   <= 1'b1;
`ifdef JTS16_MAP_ARB_RR_EN
        // Pointer only moves on a contested grant, handing the next tie over
        if (w_miss_a && w_miss_b) r_rr <= !w_pick_b;
`endif
      end

      // Data is tagged with the requested address, not the reader's current one
      if (w_capture) begin
        r_sdr_cs     <= 1'b0;
        r_flush_pend <= 1'b0;
        if (r_gnt) begin
          r_data_b  <= bus.sdr_data;
          r_tag_b   <= r_sdr_addr;
          r_valid_b <= !r_flush_pend;
        end else begin
          r_data_a  <= bus.sdr_data;
          r_tag_a   <= r_sdr_addr;
          r_valid_a <= !r_flush_pend;
        end
      end

      if (bus.flush) begin
        r_valid_a <= 1'b0;
        r_valid_b <= 1'b0;
        if (r_state == ST_WAIT && !w_capture) r_flush_pend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
